// File: rtl/tb_clk_gen_multi.sv
// Multi-channel bench clock generator: NUM_CH phase-aligned divided clocks with
// free-running, single-step and counted-burst modes, all referenced to channel 0.

module clk_gen_multi_lane #(
  parameter int DIV_W  = 8,
  parameter bit IS_REF = 1'b0
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             i_load,
  input  logic             i_run,
  input  logic             i_kill,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_clk,
  output logic             o_edge,
  output logic             o_bnd
);
  logic [DIV_W-1:0] r_div, r_cnt;
  logic             r_clk, r_edge;
  logic             w_wrap;

  assign w_wrap = (r_cnt == r_div);
  // only the reference lane reports the falling-to-rising period boundary
  assign o_bnd  = IS_REF ? (~r_clk & w_wrap) : 1'b0;
  assign o_clk  = r_clk;
  assign o_edge = r_edge;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_div  <= '0;
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_edge <= 1'b0;
    end else if (i_load) begin
      r_div  <= i_div;
      r_cnt  <= '0;
      r_clk  <= 1'b1;
      r_edge <= 1'b1;
    end else if (i_kill) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_edge <= 1'b0;
    end else if (i_run) begin
      if (w_wrap) begin
        r_cnt  <= '0;
        r_clk  <= ~r_clk;
        r_edge <= ~r_clk;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_edge <= 1'b0;
      end
    end else begin
      r_edge <= 1'b0;
    end
  end
endmodule

module tb_clk_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    nEnable,
  input  logic [1:0]              mode_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    step_i,
  input  logic [CNT_W-1:0]        burst_len_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       edge_o,
  output logic                    busy_o,
  output logic                    done_o
);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_BURST, S_STOP} state_t;

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_rem;
  logic               r_done;
  logic [NUM_CH-1:0]  w_bnd;
  logic               w_bnd0, w_last, w_load, w_run, w_kill, w_done_n;

  assign w_bnd0 = |w_bnd;
  assign w_last = (r_rem <= CNT_W'(1));

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: begin
        if (!nEnable) begin
          case (mode_i)
            2'b00:   w_state_n = S_RUN;
            2'b01:   if (step_i) w_state_n = S_STEP;
            2'b10:   if (step_i && burst_len_i != '0) w_state_n = S_BURST;
            default: w_state_n = S_IDLE;
          endcase
        end
      end
      S_RUN:          if (nEnable) w_state_n = S_IDLE;
                      else if (mode_i != 2'b00) w_state_n = w_bnd0 ? S_IDLE : S_STOP;
      S_STEP, S_BURST: if (nEnable || (w_bnd0 && w_last)) w_state_n = S_IDLE;
      S_STOP:         if (nEnable || w_bnd0) w_state_n = S_IDLE;
      default:        w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_load   = (r_state == S_IDLE) && (w_state_n != S_IDLE);
    w_run    = (r_state != S_IDLE) && (w_state_n != S_IDLE);
    w_kill   = (r_state != S_IDLE) && (w_state_n == S_IDLE);
    // zero-length burst reports completion without ever leaving IDLE
    w_done_n = ((r_state == S_IDLE) && !nEnable && mode_i == 2'b10 && step_i && burst_len_i == '0)
            || ((r_state == S_STEP || r_state == S_BURST) && !nEnable && w_bnd0 && w_last);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_rem  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_n;
      if (w_load)
        r_rem <= (w_state_n == S_BURST) ? burst_len_i :
                 (w_state_n == S_STEP)  ? CNT_W'(1)   : '0;
      else if (w_run && w_bnd0 && r_rem != '0)
        r_rem <= r_rem - 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    clk_gen_multi_lane #(.DIV_W(DIV_W), .IS_REF(k == 0)) u_lane (
      .clk    (clk),
      .nReset (nReset),
      .i_load (w_load),
      .i_run  (w_run),
      .i_kill (w_kill),
      .i_div  (div_i[k*DIV_W +: DIV_W]),
      .o_clk  (clk_o[k]),
      .o_edge (edge_o[k]),
      .o_bnd  (w_bnd[k])
    );
  end

  assign busy_o = (r_state != S_IDLE);
  assign done_o = r_done;
endmodule

// File: tb/tb_tb_clk_gen_multi.sv
// Bench for tb_clk_gen_multi: randomized scenarios checked against a phase-arithmetic model.
module tb_tb_clk_gen_multi;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        nEnable = 1'b1;
  logic [1:0]  mode_i = 2'b00;
  logic [31:0] div_i = '0;
  logic        step_i = 1'b0;
  logic [15:0] burst_len_i = '0;
  logic [3:0]  clk_o, edge_o;
  logic        busy_o, done_o;

  int total = 0;
  int bad   = 0;

  tb_clk_gen_multi dut (
    .clk(clk), .nReset(nReset), .nEnable(nEnable), .mode_i(mode_i), .div_i(div_i),
    .step_i(step_i), .burst_len_i(burst_len_i), .clk_o(clk_o), .edge_o(edge_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // reference model: channel waveform from elapsed time modulo period
  bit       m_act = 0, m_stopping = 0, m_done = 0, m_busy = 0;
  int       m_kind = 0;  // 0 auto, 1 step, 2 burst
  int       m_t = 0, m_left = 0;
  int       m_dv[NCH];
  bit [3:0] m_clk = '0, m_edge = '0;

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_act = 0; m_done = 0; m_stopping = 0;
    end else begin
      m_done = 0;
      if (m_act) begin
        if (nEnable) m_act = 0;
        else begin
          bit last;
          last = ((m_t + 1) % (2 * (m_dv[0] + 1))) == 0;
          if (m_kind == 0 && mode_i != 2'b00) m_stopping = 1;
          if (last && m_kind != 0) m_left--;
          if (last && (m_stopping || (m_kind != 0 && m_left == 0))) begin
            m_act = 0; m_done = (m_kind != 0);
          end else m_t++;
        end
      end else if (!nEnable) begin
        bit go;
        go = 0;
        if (mode_i == 2'b00) begin go = 1; m_kind = 0; end
        else if (mode_i == 2'b01 && step_i) begin go = 1; m_kind = 1; m_left = 1; end
        else if (mode_i == 2'b10 && step_i) begin
          if (burst_len_i == 0) m_done = 1;
          else begin go = 1; m_kind = 2; m_left = burst_len_i; end
        end
        if (go) begin
          m_act = 1; m_t = 0; m_stopping = 0;
          for (int k = 0; k < NCH; k++) m_dv[k] = div_i[k*8 +: 8];
        end
      end
    end
    for (int k = 0; k < NCH; k++) begin
      int ph;
      ph = m_t % (2 * (m_dv[k] + 1));
      m_clk[k]  = m_act && (ph <= m_dv[k]);
      m_edge[k] = m_act && (ph == 0);
    end
    m_busy = m_act;
  end

  task automatic test_reset();
    nReset = 1'b0; nEnable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      total++;
      if ({clk_o, edge_o, busy_o, done_o} !== 10'b0) begin
        bad++; $display("FAIL reset got=%b want=0", {clk_o, edge_o, busy_o, done_o});
      end
    end
    nReset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      total++;
      if ({clk_o, edge_o, busy_o, done_o} !== 10'b0) begin
        bad++; $display("FAIL reset_idle got=%b want=0", {clk_o, edge_o, busy_o, done_o});
      end
    end
  endtask

  task automatic test_auto();
    int e0 = 0, e1 = 0, e2 = 0;
    div_i = {8'($urandom_range(0, 7)), 8'd3, 8'd1, 8'd0};
    mode_i = 2'b00; nEnable = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      total++;
      if ({clk_o, edge_o, busy_o, done_o} !== {m_clk, m_edge, m_busy, m_done}) begin
        bad++; $display("FAIL auto c=%0d got=%b/%b/%b/%b want=%b/%b/%b/%b", c,
                        clk_o, edge_o, busy_o, done_o, m_clk, m_edge, m_busy, m_done);
      end
      if (c == 1) begin
        total++;
        if (edge_o !== 4'b1111 || clk_o !== 4'b1111) begin
          bad++; $display("FAIL auto_align got clk=%b edge=%b want 1111/1111", clk_o, edge_o);
        end
      end
      e0 += edge_o[0]; e1 += edge_o[1]; e2 += edge_o[2];
    end
    total++;
    if (e0 != 20 || e1 != 10 || e2 != 5) begin
      bad++; $display("FAIL auto_periods got=%0d/%0d/%0d want=20/10/5", e0, e1, e2);
    end
    nEnable = 1'b1;
    @(negedge clk);
    total++;
    if (clk_o !== 4'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL auto_off got clk=%b busy=%b want 0/0", clk_o, busy_o);
    end
  endtask

  task automatic test_manual();
    int dones = 0, e0 = 0;
    div_i = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), 8'd2};
    mode_i = 2'b01; nEnable = 1'b0;
    for (int s = 0; s < 3; s++) begin
      int drop;
      drop = $urandom_range(2, 5);
      for (int c = 0; c < 20; c++) begin
        step_i = (c == 0) || (c == drop);
        @(negedge clk);
        total++;
        if ({clk_o, edge_o, busy_o, done_o} !== {m_clk, m_edge, m_busy, m_done}) begin
          bad++; $display("FAIL manual s=%0d c=%0d got=%b/%b/%b/%b want=%b/%b/%b/%b", s, c,
                          clk_o, edge_o, busy_o, done_o, m_clk, m_edge, m_busy, m_done);
        end
        dones += done_o; e0 += edge_o[0];
      end
      step_i = 1'b0;
    end
    total++;
    if (dones != 3 || e0 != 3) begin
      bad++; $display("FAIL manual_count got done=%0d edges=%0d want 3/3", dones, e0);
    end
    nEnable = 1'b1;
  endtask

  task automatic test_burst();
    int e0 = 0;
    div_i = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 8'd1};
    mode_i = 2'b10; burst_len_i = 16'd5; nEnable = 1'b0; step_i = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      step_i = 1'b0;
      total++;
      if ({clk_o, edge_o, busy_o, done_o} !== {m_clk, m_edge, m_busy, m_done}) begin
        bad++; $display("FAIL burst5 c=%0d got=%b/%b/%b/%b want=%b/%b/%b/%b", c,
                        clk_o, edge_o, busy_o, done_o, m_clk, m_edge, m_busy, m_done);
      end
      if (c == 21) begin
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
          bad++; $display("FAIL burst5_done got done=%b busy=%b want 1/0", done_o, busy_o);
        end
      end
      e0 += edge_o[0];
    end
    total++;
    if (e0 != 5) begin bad++; $display("FAIL burst5_edges got=%0d want=5", e0); end
    burst_len_i = 16'd0; step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    total++;
    if (done_o !== 1'b1 || edge_o !== 4'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL burst0 got done=%b edge=%b busy=%b want 1/0000/0", done_o, edge_o, busy_o);
    end
    @(negedge clk);
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL burst0_after got done=%b busy=%b want 0/0", done_o, busy_o);
    end
    repeat (3) begin
      int len, n, seen;
      bit fin;
      len = $urandom_range(1, 6); n = 0; seen = 0; fin = 0;
      div_i = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
               8'($urandom_range(0, 3))};
      burst_len_i = 16'(len); step_i = 1'b1;
      while (!fin && n < 100) begin
        @(negedge clk);
        step_i = 1'b0; n++;
        total++;
        if ({clk_o, edge_o, busy_o, done_o} !== {m_clk, m_edge, m_busy, m_done}) begin
          bad++; $display("FAIL burst_rand n=%0d got=%b/%b/%b/%b want=%b/%b/%b/%b", n,
                          clk_o, edge_o, busy_o, done_o, m_clk, m_edge, m_busy, m_done);
        end
        seen += edge_o[0];
        if (done_o) fin = 1;
      end
      total++;
      if (!fin || seen != len) begin
        bad++; $display("FAIL burst_rand_len got edges=%0d fin=%0d want %0d/1", seen, fin, len);
      end
    end
    nEnable = 1'b1;
  endtask

  task automatic test_abort();
    int n = 0, cyc = 0, dones = 0;
    bit hit = 0;
    div_i = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
             8'($urandom_range(1, 3))};
    mode_i = 2'b10; burst_len_i = 16'd100; nEnable = 1'b0; step_i = 1'b1;
    while (!hit && cyc < 200) begin
      @(negedge clk);
      step_i = 1'b0; cyc++;
      n += edge_o[0];
      if (n == 10) hit = 1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL abort_wait got edges=%0d want=10", n); end
    nEnable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({clk_o, edge_o, busy_o} !== 9'b0) begin
        bad++; $display("FAIL abort c=%0d got clk=%b edge=%b busy=%b want 0", c, clk_o, edge_o, busy_o);
      end
      dones += done_o;
    end
    total++;
    if (dones != 0) begin bad++; $display("FAIL abort_done got=%0d want=0", dones); end
    nEnable = 1'b0; step_i = 1'b1; hit = 0; cyc = 0;
    while (!hit && cyc < 50) begin
      @(negedge clk);
      step_i = 1'b0; cyc++;
      if (cyc > 3 && clk_o[0] && !edge_o[0]) hit = 1;
    end
    #2 nReset = 1'b0;
    #1;
    total++;
    if (!hit || {clk_o, edge_o, busy_o, done_o} !== 10'b0) begin
      bad++; $display("FAIL async_reset hit=%0d got=%b want=0", hit, {clk_o, edge_o, busy_o, done_o});
    end
    @(negedge clk);
    nReset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({clk_o, edge_o, busy_o, done_o} !== {m_clk, m_edge, m_busy, m_done}) begin
        bad++; $display("FAIL post_reset got=%b/%b/%b/%b want=%b/%b/%b/%b",
                        clk_o, edge_o, busy_o, done_o, m_clk, m_edge, m_busy, m_done);
      end
    end
    nEnable = 1'b1;
  endtask

  task automatic test_stop();
    int n = 0, e = 0, f = 0, cyc = 0;
    div_i = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), 8'd3};
    mode_i = 2'b00; nEnable = 1'b0;
    while (f == 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      total++;
      if ({clk_o, edge_o, busy_o, done_o} !== {m_clk, m_edge, m_busy, m_done}) begin
        bad++; $display("FAIL stop c=%0d got=%b/%b/%b/%b want=%b/%b/%b/%b", cyc,
                        clk_o, edge_o, busy_o, done_o, m_clk, m_edge, m_busy, m_done);
      end
      if (e == 0 && edge_o[0]) begin
        n++;
        if (n == 2) begin
          e = cyc; mode_i = 2'b01;
          div_i = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
                   8'($urandom_range(0, 5))};
        end
      end else if (e != 0 && !busy_o) f = cyc;
    end
    total++;
    if (e == 0 || f - e != 8) begin
      bad++; $display("FAIL stop_len got=%0d want=8", f - e);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (clk_o !== 4'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
        bad++; $display("FAIL stop_park got clk=%b busy=%b done=%b want 0/0/0", clk_o, busy_o, done_o);
      end
    end
    mode_i = 2'b00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if ({clk_o, edge_o, busy_o, done_o} !== {m_clk, m_edge, m_busy, m_done}) begin
        bad++; $display("FAIL reactivate c=%0d got=%b/%b/%b/%b want=%b/%b/%b/%b", c,
                        clk_o, edge_o, busy_o, done_o, m_clk, m_edge, m_busy, m_done);
      end
    end
    nEnable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_auto();
    test_manual();
    test_burst();
    test_abort();
    test_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
